ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/ram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// Handshake: a requester raises req with we/addr/wdata stable and keeps them until its one-cycle ack.
interface ram_arbiter_if;
  logic        req0;
  logic        we0;
  logic [11:0] addr0;
  logic [7:0]  wdata0;
  logic        ack0;
  logic        err0;

  logic        req1;
  logic        we1;
  logic [11:0] addr1;
  logic [7:0]  wdata1;
  logic        ack1;
  logic        err1;

  logic [7:0]  rdata;
  logic        busy;
  logic        gnt;

  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_chip_en;
  logic        ram_wrt_en;
  logic        ram_out_en;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_dout,
    output ack0, err0, ack1, err1,
    output rdata, busy, gnt,
    output ram_addr, ram_din, ram_chip_en, ram_wrt_en, ram_out_en
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, err0, ack1, err1,
    input  rdata, busy, gnt
  );

  modport ram (
    input  ram_addr, ram_din, ram_chip_en, ram_wrt_en, ram_out_en,
    output ram_dout
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter and setup/strobe/done access sequencer for the 8-bit asynchronous work RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 always wins ties.
module ram_arbiter #(
  parameter int DEPTH         = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_arbiter_if.slave bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t      state, state_nxt;
  logic        cur_we, cur_we_nxt;
  logic        gnt_q, gnt_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic [7:0]  rdata_q, rdata_nxt;
  logic        ack0_q, ack0_nxt;
  logic        ack1_q, ack1_nxt;
  logic        err0_q, err0_nxt;
  logic        err1_q, err1_nxt;
  logic        busy_q, busy_nxt;
  logic [11:0] addr_q, addr_nxt;
  logic [7:0]  din_q, din_nxt;
  logic        ce_q, ce_nxt;
  logic        wr_q, wr_nxt;
  logic        oe_q, oe_nxt;

  logic        win;
  logic        any_req;
  logic        sel_we;
  logic        sel_oor;
  logic [11:0] sel_addr;
  logic [7:0]  sel_wdata;

  assign any_req = bus.req0 | bus.req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Last-grant pointer starts at port 1 so port 0 takes the first tie.
  logic last_q;

  assign win = (bus.req0 && bus.req1) ? ~last_q : ~bus.req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_q <= win;
    end
  end
`else
  assign win = ~bus.req0;
`endif

  assign sel_we    = win ? bus.we1    : bus.we0;
  assign sel_addr  = win ? bus.addr1  : bus.addr0;
  assign sel_wdata = win ? bus.wdata1 : bus.wdata0;
  assign sel_oor   = (sel_addr >> DEPTH) != 12'd0;

  always_comb begin
    state_nxt  = state;
    cur_we_nxt = cur_we;
    gnt_nxt    = gnt_q;
    cnt_nxt    = cnt_q;
    rdata_nxt  = rdata_q;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    err0_nxt   = 1'b0;
    err1_nxt   = 1'b0;
    addr_nxt   = addr_q;
    din_nxt    = din_q;
    ce_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    oe_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nxt    = win;
          cur_we_nxt = sel_we;
          if (sel_oor) begin
            // Out-of-range access never touches the RAM pins.
            state_nxt = DONE;
            rdata_nxt = 8'h00;
            ack0_nxt  = ~win;
            ack1_nxt  = win;
            err0_nxt  = ~win;
            err1_nxt  = win;
          end else begin
            state_nxt = SETUP;
            addr_nxt  = sel_addr;
            din_nxt   = sel_wdata;
            ce_nxt    = 1'b1;
          end
        end
      end

      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = CNT_LOAD;
        ce_nxt    = 1'b1;
        wr_nxt    = cur_we;
        oe_nxt    = ~cur_we;
      end

      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_nxt = DONE;
          if (!cur_we) begin
            rdata_nxt = bus.ram_dout;
          end
          ack0_nxt = ~gnt_q;
          ack1_nxt = gnt_q;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
          ce_nxt  = 1'b1;
          wr_nxt  = cur_we;
          oe_nxt  = ~cur_we;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_we  <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= 12'h000;
      din_q   <= 8'h00;
      ce_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_we  <= cur_we_nxt;
      gnt_q   <= gnt_nxt;
      cnt_q   <= cnt_nxt;
      rdata_q <= rdata_nxt;
      ack0_q  <= ack0_nxt;
      ack1_q  <= ack1_nxt;
      err0_q  <= err0_nxt;
      err1_q  <= err1_nxt;
      busy_q  <= busy_nxt;
      addr_q  <= addr_nxt;
      din_q   <= din_nxt;
      ce_q    <= ce_nxt;
      wr_q    <= wr_nxt;
      oe_q    <= oe_nxt;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.err0        = err0_q;
  assign bus.err1        = err1_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.gnt         = gnt_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_din     = din_q;
  assign bus.ram_chip_en = ce_q;
  assign bus.ram_wrt_en  = wr_q;
  assign bus.ram_out_en  = oe_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (STROBE_CYCLES 1 and 4) with behavioural RAMs,
// directed transactions, and an ack-driven scoreboard.
module tb_ram_arbiter;
  localparam int W = 10;  // {port, err, rdata}

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if ia();
  ram_arbiter_if ib();
  logic [1:0] dbg_a, dbg_b;

  ram_arbiter #(.DEPTH(8), .STROBE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave), .dbg_state(dbg_a)
  );
  ram_arbiter #(.DEPTH(8), .STROBE_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave), .dbg_state(dbg_b)
  );

  // Driven stimulus, indexed [instance][port]
  logic [1:0]  req_d [2];
  logic [1:0]  we_d [2];
  logic [11:0] addr_d [2][2];
  logic [7:0]  wdata_d [2][2];

  assign ia.req0 = req_d[0][0];  assign ia.req1 = req_d[0][1];
  assign ia.we0  = we_d[0][0];   assign ia.we1  = we_d[0][1];
  assign ia.addr0 = addr_d[0][0]; assign ia.addr1 = addr_d[0][1];
  assign ia.wdata0 = wdata_d[0][0]; assign ia.wdata1 = wdata_d[0][1];
  assign ib.req0 = req_d[1][0];  assign ib.req1 = req_d[1][1];
  assign ib.we0  = we_d[1][0];   assign ib.we1  = we_d[1][1];
  assign ib.addr0 = addr_d[1][0]; assign ib.addr1 = addr_d[1][1];
  assign ib.wdata0 = wdata_d[1][0]; assign ib.wdata1 = wdata_d[1][1];

  // Observed outputs, indexed [instance]
  logic [1:0]  ack_o [2];
  logic [1:0]  err_o [2];
  logic [7:0]  rdata_o [2];
  logic [11:0] raddr_o [2];
  logic [7:0]  rdin_o [2];
  logic        ce_o [2], wr_o [2], oe_o [2], busy_o [2], gnt_o [2];

  assign ack_o[0] = {ia.ack1, ia.ack0};  assign ack_o[1] = {ib.ack1, ib.ack0};
  assign err_o[0] = {ia.err1, ia.err0};  assign err_o[1] = {ib.err1, ib.err0};
  assign rdata_o[0] = ia.rdata;          assign rdata_o[1] = ib.rdata;
  assign raddr_o[0] = ia.ram_addr;       assign raddr_o[1] = ib.ram_addr;
  assign rdin_o[0] = ia.ram_din;         assign rdin_o[1] = ib.ram_din;
  assign ce_o[0] = ia.ram_chip_en;       assign ce_o[1] = ib.ram_chip_en;
  assign wr_o[0] = ia.ram_wrt_en;        assign wr_o[1] = ib.ram_wrt_en;
  assign oe_o[0] = ia.ram_out_en;        assign oe_o[1] = ib.ram_out_en;
  assign busy_o[0] = ia.busy;            assign busy_o[1] = ib.busy;
  assign gnt_o[0] = ia.gnt;              assign gnt_o[1] = ib.gnt;

  // Behavioural asynchronous RAMs: combinational read, write on an edge with the strobe high
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  bit loaded = 1'b0;

  assign ia.ram_dout = mem_a[ia.ram_addr[7:0]];
  assign ib.ram_dout = mem_b[ib.ram_addr[7:0]];

  always @(posedge clk) begin
    if (!loaded) begin
      mem_a[8'h20] <= 8'h5A;
      mem_a[8'h30] <= 8'h11;
      mem_b[8'hFF] <= 8'h3C;
      loaded <= 1'b1;
    end else begin
      if (ia.ram_chip_en && ia.ram_wrt_en) mem_a[ia.ram_addr[7:0]] <= ia.ram_din;
      if (ib.ram_chip_en && ib.ram_wrt_en) mem_b[ib.ram_addr[7:0]] <= ib.ram_din;
    end
  end

  // Scoreboard
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] mon_e;
  bit           mon_have;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && ack_o[i] != 2'b00) begin
        mon_have = (i == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        if (!mon_have) begin
          chk("unexpected_ack", 32'(ack_o[i]), 32'd0);
        end else begin
          if (i == 0) mon_e = exp_q0.pop_front();
          else        mon_e = exp_q1.pop_front();
          chk("ack_port", 32'(ack_o[i]), mon_e[9] ? 32'd2 : 32'd1);
          chk("err_flag", 32'(err_o[i]), mon_e[8] ? (mon_e[9] ? 32'd2 : 32'd1) : 32'd0);
          chk("rdata", 32'(rdata_o[i]), 32'(mon_e[7:0]));
          chk("gnt", 32'(gnt_o[i]), 32'(mon_e[9]));
          chk("busy_in_done", 32'(busy_o[i]), 32'd1);
        end
      end
    end
  end

  // Single transaction driver with latency and strobe-shape checks
  task automatic do_txn(input int inst, input int port, input bit we,
                        input logic [11:0] addr, input logic [7:0] wdata,
                        input int lat, input int scyc, input bit oor,
                        input logic [7:0] exp_rd);
    int k, ce_n, st_n, wrong_n;
    bit got, pre_ok;
    logic [W-1:0] e;
    k = 0; ce_n = 0; st_n = 0; wrong_n = 0; got = 1'b0; pre_ok = oor;
    e = {port[0], oor, exp_rd};
    if (inst == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
    @(negedge clk);
    req_d[inst][port]   = 1'b1;
    we_d[inst][port]    = we;
    addr_d[inst][port]  = addr;
    wdata_d[inst][port] = wdata;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (ce_o[inst]) ce_n++;
      if (we ? wr_o[inst] : oe_o[inst]) st_n++;
      if (we ? oe_o[inst] : wr_o[inst]) wrong_n++;
      if (k == 1 && !oor) pre_ok = ce_o[inst] && !wr_o[inst] && !oe_o[inst];
      if (ack_o[inst][port]) got = 1'b1;
    end
    req_d[inst][port] = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", k, lat);
    chk("chip_en_cycles", ce_n, oor ? 0 : scyc + 1);
    chk("strobe_cycles", st_n, oor ? 0 : scyc);
    chk("wrong_strobe", wrong_n, 0);
    chk("setup_before_strobe", 32'(pre_ok), 32'd1);
    @(posedge clk); #1;
    chk("idle_after", 32'(busy_o[inst]), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, k;
    bit p;
    for (int i = 0; i < 2; i++) begin
      req_d[i] = 2'b00;
      we_d[i]  = 2'b00;
      for (int j = 0; j < 2; j++) begin
        addr_d[i][j]  = 12'h000;
        wdata_d[i][j] = 8'h00;
      end
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", 32'(ack_o[i]), 32'd0);
      chk("rst_err", 32'(err_o[i]), 32'd0);
      chk("rst_busy_gnt", 32'({busy_o[i], gnt_o[i]}), 32'd0);
      chk("rst_rdata", 32'(rdata_o[i]), 32'd0);
      chk("rst_ram_addr_din", 32'({raddr_o[i], rdin_o[i]}), 32'd0);
      chk("rst_strobes", 32'({ce_o[i], wr_o[i], oe_o[i]}), 32'd0);
    end
    chk("rst_state", 32'({dbg_a, dbg_b}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Port 0 write then read on the single-strobe instance
    do_txn(0, 0, 1'b1, 12'h010, 8'hA5, 3, 1, 1'b0, 8'h00);
    chk("mem_written", 32'(mem_a[8'h10]), 32'hA5);
    do_txn(0, 0, 1'b0, 12'h010, 8'h00, 3, 1, 1'b0, 8'hA5);
    // Port 1 read of preloaded data with a 4-cycle strobe
    do_txn(1, 1, 1'b0, 12'h0FF, 8'h00, 6, 4, 1'b0, 8'h3C);
    // Out-of-range read
    do_txn(0, 0, 1'b0, 12'h100, 8'h00, 1, 1, 1'b1, 8'h00);
    // Port 1 write then read; rdata holds across the write
    do_txn(0, 1, 1'b1, 12'h040, 8'hC3, 3, 1, 1'b0, 8'h00);
    do_txn(0, 1, 1'b0, 12'h040, 8'h00, 3, 1, 1'b0, 8'hC3);
    // Out-of-range write on port 1 leaves RAM untouched
    do_txn(0, 1, 1'b1, 12'hFFF, 8'h99, 1, 1, 1'b1, 8'h00);

    // Simultaneous requests from a fresh reset
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      p = RR ? t[0] : 1'b0;
      exp_q0.push_back({p, 1'b0, p ? 8'h5A : 8'hA5});
    end
    @(negedge clk);
    we_d[0] = 2'b00;
    addr_d[0][0] = 12'h010;
    addr_d[0][1] = 12'h020;
    req_d[0] = 2'b11;
    n = 0; n1 = 0; k = 0;
    while (n < 4 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (ack_o[0] != 2'b00) begin
        n++;
        if (ack_o[0][1]) n1++;
      end
    end
    req_d[0] = 2'b00;
    chk("tie_acks", n, 4);
    chk("tie_port1_acks", n1, RR ? 2 : 0);
    chk("tie_cycles", k, 15);
    @(posedge clk); #1;

    // Reset during the write strobe aborts the access
    @(negedge clk);
    req_d[0][0] = 1'b1; we_d[0][0] = 1'b1;
    addr_d[0][0] = 12'h030; wdata_d[0][0] = 8'h77;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort_pre_wr", 32'(wr_o[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes_drop", 32'({ce_o[0], wr_o[0], oe_o[0]}), 32'd0);
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    req_d[0][0] = 1'b0; we_d[0][0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_o[0] != 2'b00) n++;
    end
    chk("abort_no_ack", n, 0);
    chk("abort_mem_kept", 32'(mem_a[8'h30]), 32'h11);
    do_txn(0, 0, 1'b0, 12'h030, 8'h00, 3, 1, 1'b0, 8'h11);

    repeat (2) @(posedge clk);
    #1;
    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
